// File: rtl/md_hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// md_hazard_unit_pkg
// Shared decode constants and helpers for the multiply/divide (HI/LO) hazard
// unit of the 5-stage MIPS pipeline.
//   - Instruction field slices (opcode, funct).
//   - SPECIAL / SPECIAL2 opcodes and every HI/LO-related funct code.
//   - Countdown state type (IDLE while the count is zero, BUSY otherwise).
// Optional decode: `MD_MADD_EN` (consumed by md_instr_classifier).
// ---------------------------------------------------------------------------
package md_hazard_unit_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

  // SPECIAL funct codes
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  // SPECIAL2 funct codes (MADD family)
  localparam logic [5:0] FN_MADD  = 6'b000000;
  localparam logic [5:0] FN_MADDU = 6'b000001;
  localparam logic [5:0] FN_MSUB  = 6'b000100;
  localparam logic [5:0] FN_MSUBU = 6'b000101;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] instr);
    return instr[5:0];
  endfunction

endpackage : md_hazard_unit_pkg

// File: rtl/md_instr_classifier.sv
// ---------------------------------------------------------------------------
// md_instr_classifier
// Purely combinational decode of one instruction word into its HI/LO role.
// Ports:
//   instr     in  32  instruction word
//   md_start  out  1  mult/multu/div/divu (plus MADD family when enabled)
//   hilo_user out  1  reads or writes HI/LO (md_start, mfhi, mflo, mthi, mtlo)
//   is_div    out  1  div/divu (selects the longer latency)
// Optional decode: define `MD_MADD_EN` to treat madd/maddu/msub/msubu
// (SPECIAL2) as multiply-latency MDU instructions.
// ---------------------------------------------------------------------------
module md_instr_classifier
  import md_hazard_unit_pkg::*;
(
  input  logic [31:0] instr,
  output logic        md_start,
  output logic        hilo_user,
  output logic        is_div
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [19:0] fields_unused;

  assign opcode        = opcode_of(instr);
  assign funct         = funct_of(instr);
  assign fields_unused = instr[25:6];  // register/shamt fields play no part in HI/LO hazards

  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves
    // one unassigned, which would otherwise infer a latch.
    md_start  = 1'b0;
    hilo_user = 1'b0;
    is_div    = 1'b0;

    if (opcode == OP_SPECIAL) begin
      unique case (funct)
        FN_MULT, FN_MULTU: begin
          md_start  = 1'b1;
          hilo_user = 1'b1;
        end
        FN_DIV, FN_DIVU: begin
          md_start  = 1'b1;
          hilo_user = 1'b1;
          is_div    = 1'b1;
        end
        FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO: hilo_user = 1'b1;
        default: ;
      endcase
    end

`ifdef MD_MADD_EN
    if (opcode == OP_SPECIAL2) begin
      unique case (funct)
        FN_MADD, FN_MADDU, FN_MSUB, FN_MSUBU: begin
          md_start  = 1'b1;
          hilo_user = 1'b1;
        end
        default: ;
      endcase
    end
`endif
  end

endmodule : md_instr_classifier

// File: rtl/md_hazard_unit.sv
// ---------------------------------------------------------------------------
// md_hazard_unit
// HI/LO hazard tracking for the multiply/divide unit. An MDU op leaving E
// loads a latency countdown; HI/LO users in D stall until it expires.
// Ports:
//   clk            in   1      rising-edge clock
//   reset          in   1      synchronous, active-high reset
//   instr_d        in   32     D-stage instruction
//   instr_e        in   32     E-stage instruction
//   instr_e_valid  in   1      E-stage slot holds a real instruction
//   mdu_flush      in   1      exception/eret flush, aborts in-flight op
//   stall_d        out  1      freeze PC/F/D, bubble into E
//   busy           out  1      HI/LO result pending
//   done           out  1      one-cycle pulse when the countdown finishes
//   remaining      out  CNT_W  cycles left (0 when idle)
// Optional decode: `MD_MADD_EN` (see md_instr_classifier).
// Parameters must satisfy 2**CNT_W > max(MULT_CYCLES, DIV_CYCLES).
// ---------------------------------------------------------------------------
module md_hazard_unit
  import md_hazard_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_d,
  input  logic [31:0]      instr_e,
  input  logic             instr_e_valid,
  input  logic             mdu_flush,
  output logic             stall_d,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             md_start_e;
  logic             is_div_e;
  logic             hilo_user_e_unused;
  logic             md_start_d_unused;
  logic             hilo_user_d;
  logic             is_div_d_unused;
  logic             start_e;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             done_next;
  md_state_e        state;

  md_instr_classifier u_class_d (
    .instr     (instr_d),
    .md_start  (md_start_d_unused),
    .hilo_user (hilo_user_d),
    .is_div    (is_div_d_unused)
  );

  md_instr_classifier u_class_e (
    .instr     (instr_e),
    .md_start  (md_start_e),
    .hilo_user (hilo_user_e_unused),
    .is_div    (is_div_e)
  );

  // A flush in the same cycle kills the start: the op never reaches the MDU.
  assign start_e = instr_e_valid & md_start_e & ~mdu_flush;

  // The FSM state is fully encoded by the counter, so it is decoded rather
  // than stored separately.
  assign state = (count != '0) ? MD_BUSY : MD_IDLE;

  always_comb begin
    count_next = count;
    done_next  = 1'b0;
    if (mdu_flush) begin
      count_next = '0;                          // abort: no done pulse
    end else if (start_e) begin
      count_next = is_div_e ? DIV_LOAD : MULT_LOAD;  // a reload restarts the wait
    end else begin
      unique case (state)
        MD_BUSY: begin
          count_next = count - CNT_ONE;
          done_next  = (count == CNT_ONE);
        end
        default: ;                              // idle: nothing to count
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    if (reset) begin
      count <= '0;
      done  <= 1'b0;
    end else begin
      count <= count_next;
      done  <= done_next;
    end
  end

  assign busy      = (state == MD_BUSY);
  assign remaining = count;
  // A starting op stalls its D-stage consumer in the same cycle, before the
  // counter has loaded.
  assign stall_d   = hilo_user_d & (busy | start_e);

endmodule : md_hazard_unit

// File: tb/tb_md_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_md_hazard_unit
// Directed scenarios followed by randomized traffic, checked every cycle
// against a timeline model: each accepted MDU op records the cycle at which
// HI/LO become available; busy/remaining/done/stall_d follow from that.
// ---------------------------------------------------------------------------
module tb_md_hazard_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int CNT_W       = 8;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] MULT_T01 = 32'h0109_0018;  // mult $t0,$t1
  localparam logic [31:0] DIV_T01  = 32'h0109_001A;  // div  $t0,$t1
  localparam logic [31:0] MFHI_T2  = 32'h0000_5010;  // mfhi $t2
  localparam logic [31:0] MFLO_T2  = 32'h0000_5012;  // mflo $t2
  localparam logic [31:0] ADDU_T2  = 32'h0109_5021;  // addu $t2,$t0,$t1
  localparam logic [31:0] MADD_T01 = 32'h7109_0000;  // madd $t0,$t1

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      instr_d = '0;
  logic [31:0]      instr_e = '0;
  logic             instr_e_valid = 1'b0;
  logic             mdu_flush = 1'b0;
  logic             stall_d;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;

  int checks = 0;
  int errors = 0;

  // Timeline model
  int cyc      = 0;
  int ready_at = 0;    // first cycle with HI/LO available
  bit pending  = 0;    // op still on track to finish (not flushed/reset)

  md_hazard_unit #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_d       (instr_d),
    .instr_e       (instr_e),
    .instr_e_valid (instr_e_valid),
    .mdu_flush     (mdu_flush),
    .stall_d       (stall_d),
    .busy          (busy),
    .done          (done),
    .remaining     (remaining)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, actual, expected);
    end
  endtask

  // Reference decode written from the instruction set tables.
  function automatic bit m_start(input logic [31:0] i);
    bit r;
    r = (i[31:26] == 6'd0) && (i[5:0] inside {6'h18, 6'h19, 6'h1A, 6'h1B});
`ifdef MD_MADD_EN
    r = r || ((i[31:26] == 6'h1C) && (i[5:0] inside {6'h00, 6'h01, 6'h04, 6'h05}));
`endif
    return r;
  endfunction

  function automatic bit m_hilo(input logic [31:0] i);
    return m_start(i) || ((i[31:26] == 6'd0) && (i[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13}));
  endfunction

  function automatic int m_latency(input logic [31:0] i);
    return ((i[31:26] == 6'd0) && (i[5:0] inside {6'h1A, 6'h1B})) ? DIV_CYCLES : MULT_CYCLES;
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
    logic [19:0] mid;
    mid = 20'($urandom);
    return {op, mid, fn};
  endfunction

  function automatic logic [31:0] pick_instr();
    logic [5:0] madd_fn [4];
    madd_fn = '{6'h00, 6'h01, 6'h04, 6'h05};
    case ($urandom_range(0, 11))
      0:  return mk(6'h00, 6'h18);
      1:  return mk(6'h00, 6'h19);
      2:  return mk(6'h00, 6'h1A);
      3:  return mk(6'h00, 6'h1B);
      4:  return mk(6'h00, 6'h10);
      5:  return mk(6'h00, 6'h12);
      6:  return mk(6'h00, 6'h11);
      7:  return mk(6'h00, 6'h13);
      8:  return mk(6'h1C, madd_fn[$urandom_range(0, 3)]);
      9:  return mk(6'h00, 6'h21);
      10: return mk(6'h23, 6'($urandom));
      default: return $urandom;
    endcase
  endfunction

  // Drive one cycle of inputs, compare outputs with the model, then advance
  // the model across the coming rising edge.
  task automatic step(input logic rst, input logic [31:0] d, input logic [31:0] e,
                      input logic v, input logic fl, input bit chk);
    int exp_rem;
    bit start;
    @(negedge clk);
    reset = rst; instr_d = d; instr_e = e; instr_e_valid = v; mdu_flush = fl;
    #1;
    exp_rem = (ready_at > cyc) ? ready_at - cyc : 0;
    start   = v && m_start(e) && !fl;
    if (chk) begin
      check("remaining", 32'(remaining), 32'(exp_rem));
      check("busy", 32'(busy), 32'(exp_rem != 0));
      check("done", 32'(done), 32'(pending && (cyc == ready_at)));
      check("stall_d", 32'(stall_d), 32'(m_hilo(d) && (exp_rem != 0 || start)));
    end
    if (rst || fl) begin
      ready_at = 0;
      pending  = 0;
    end else if (start) begin
      ready_at = cyc + m_latency(e) + 1;
      pending  = 1;
    end
    cyc++;
  endtask

  initial begin
    // Reset, then confirm the cleared state.
    step(1, NOP, NOP, 0, 0, 0);
    step(1, NOP, MULT_T01, 1, 0, 0);
    step(0, MFHI_T2, NOP, 0, 0, 1);

    // mult in E with dependent mfhi in D: stall t..t+5, done at t+6.
    step(0, MFHI_T2, MULT_T01, 1, 0, 1);
    repeat (5) step(0, MFHI_T2, NOP, 0, 0, 1);
    step(0, MFHI_T2, NOP, 0, 0, 1);
    step(0, NOP, NOP, 0, 0, 1);

    // div, then an independent addu in D: never stalls.
    step(0, ADDU_T2, DIV_T01, 1, 0, 1);
    repeat (11) step(0, ADDU_T2, NOP, 0, 0, 1);

    // div aborted by a flush three cycles later: no done pulse.
    step(0, NOP, DIV_T01, 1, 0, 1);
    step(0, NOP, NOP, 0, 0, 1);
    step(0, NOP, NOP, 0, 0, 1);
    step(0, MFLO_T2, NOP, 0, 1, 1);
    repeat (12) step(0, MFLO_T2, NOP, 0, 0, 1);

    // mult in a bubble slot: ignored.
    repeat (3) step(0, MFHI_T2, MULT_T01, 0, 0, 1);

    // flush and start together: flush wins.
    step(0, MFHI_T2, MULT_T01, 1, 1, 1);
    step(0, MFHI_T2, NOP, 0, 0, 1);

    // reset in the fourth busy cycle of a div.
    step(0, NOP, DIV_T01, 1, 0, 1);
    repeat (3) step(0, NOP, NOP, 0, 0, 1);
    step(1, MFLO_T2, NOP, 0, 0, 1);
    repeat (2) step(0, MFLO_T2, NOP, 0, 0, 1);

    // reload while busy: the new latency wins.
    step(0, NOP, MULT_T01, 1, 0, 1);
    step(0, NOP, NOP, 0, 0, 1);
    step(0, MFHI_T2, DIV_T01, 1, 0, 1);
    repeat (12) step(0, MFHI_T2, NOP, 0, 0, 1);

    // madd: counts only when the MADD decode is built in.
    step(0, MFHI_T2, MADD_T01, 1, 0, 1);
    repeat (7) step(0, MFHI_T2, NOP, 0, 0, 1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic rst_r, fl_r, v_r;
      logic [31:0] d_r, e_r;
      rst_r = ($urandom_range(0, 99) < 2);
      fl_r  = ($urandom_range(0, 99) < 5);
      v_r   = ($urandom_range(0, 99) < 75);
      d_r   = pick_instr();
      e_r   = ($urandom_range(0, 99) < 40) ? pick_instr() : NOP;
      step(rst_r, d_r, e_r, v_r, fl_r, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_md_hazard_unit

// File: doc/md_hazard_unit.md
Name: md_hazard_unit

Overview:
- Successor to the single-cycle move-from detector; owns multiply/divide (HI/LO) hazard tracking for the 5-stage MIPS pipeline.
- Decodes the E-stage instruction to start a latency countdown for mult/multu/div/divu.
- Decodes the D-stage instruction to raise a D-stage stall while HI/LO are unavailable.
- Latencies are parametrised. An optional MADD-family decode is available.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu leaves E (range 1..255)
- DIV_CYCLES, 10, busy cycles after a div/divu leaves E (range 1..255)
- CNT_W, 8, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- instr_d  input  32  instruction in D stage
- instr_e  input  32  instruction in E stage
- instr_e_valid  input  1  E-stage instruction is real (not a bubble or flushed slot)
- mdu_flush  input  1  exception/eret flush; aborts an in-flight operation
- stall_d  output  1  freeze PC/F/D and insert a bubble into E
- busy  output  1  HI/LO result pending
- done  output  1  one-cycle pulse on the cycle the countdown finishes
- remaining  output  CNT_W  cycles left in the countdown (0 when idle)

Behaviour:
- Reset: synchronous, active-high; clk and reset as above. On reset, count=0, busy=0, done=0, stall_d=0, remaining=0.
- Decode (combinational, opcode/funct fields; all funct codes below have opcode 000000):
  - md_start(i): mult 011000, multu 011001, div 011010, divu 011011.
  - hilo_user(i): md_start(i), or mfhi 010000, mflo 010010, mthi 010001, mtlo 010011.
  - is_div(i): funct 011010 or 011011.
- start_e = instr_e_valid & md_start(instr_e) & ~mdu_flush.
- State machine:
  - IDLE: count==0.
  - BUSY: count!=0.
- Sequential, per rising edge of clk, in priority order:
  1. reset: clear everything.
  2. mdu_flush: count <= 0, done <= 0 (abort; no done pulse).
  3. start_e: count <= is_div(instr_e) ? DIV_CYCLES : MULT_CYCLES. If already BUSY, this is a reload and the new latency wins.
  4. count!=0: count <= count-1. done <= (count==1).
  5. otherwise: done <= 0.
- Outputs:
  - busy = (count != 0), combinational from the register.
  - remaining = count.
  - stall_d = hilo_user(instr_d) & (busy | start_e), combinational.
- Timing: mult in E at cycle t gives count=MULT_CYCLES at t+1 and busy for cycles t+1..t+MULT_CYCLES. done is high at cycle t+MULT_CYCLES+1, the first cycle a D-stage mfhi may proceed. stall_d covers t..t+MULT_CYCLES.
- Instructions without a HI/LO dependency in D never stall, even while busy.
- Invariant: count never underflows. Decrement occurs only when count!=0.
- Simultaneous mdu_flush and start_e: the flush wins; start_e is suppressed by definition.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined: md_start and hilo_user also match opcode 011100 with funct madd 000000, maddu 000001, msub 000100, msubu 000101. These load MULT_CYCLES.
- Undefined: those encodings are not MDU instructions and never stall or start the counter.

Decomposition:
- Shared macros header (existing):
  - opcode/funct field slices.
  - Constants for the SPECIAL and SPECIAL2 opcodes and every funct code above.
- Sub-module md_instr_classifier:
  - Purely combinational.
  - Input: instr[31:0].
  - Outputs: md_start, hilo_user, is_div.
  - Instantiated twice (D and E stages).
  - Holds the MD_MADD_EN conditional decode.
- Top level contains only the counter, done register and stall logic.

Test Plan:
- mult $t0,$t1 in E at t, mfhi in D at t -> stall_d=1 for t..t+5; done=1 at t+6; stall_d=0 at t+6; remaining counts 5,4,3,2,1,0.
- div in E, then addu in D during busy -> stall_d=0 throughout; busy=1 for 10 cycles; done pulse after 10.
- div in E at t, mdu_flush at t+3 -> count=0 at t+4; no done pulse; mflo in D at t+4 gives stall_d=0.
- mult in E with instr_e_valid=0 -> count stays 0, busy=0, stall_d=0.
- reset asserted at cycle 4 of a div -> next cycle count=0, busy=0, done=0.
- madd (0x7109_0000) in E -> with MD_MADD_EN, busy for MULT_CYCLES; without it, busy stays 0.
